// File: rtl/toggle_event_decoder.sv
// Receive side of a pulse-to-toggle link: synchronises tog_in, pulses evt per transition and
// hands accumulated event counts out over valid/ready. Optional macro: TOG_DEC_GLITCH_FILTER_EN.
module toggle_event_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tog_in,
  output logic             evt,
  output logic             cnt_valid,
  output logic [CNT_W-1:0] cnt_data,
  input  logic             cnt_ready,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  // Handshake: a count transfers on a rising edge where cnt_valid && cnt_ready; while
  // cnt_valid is high and cnt_ready low, cnt_data holds its value.

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_PEND     = 2'd1,
    ST_PEND_ACC = 2'd2,
    ST_SAT      = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  logic [SYNC_STAGES-1:0] s;
  logic                   s_last;
  logic                   tog_prev;
  logic                   tog_prev_n;
  logic                   det;
  logic [CNT_W-1:0]       acc;
  logic [CNT_W-1:0]       acc_n;
  logic [CNT_W-1:0]       data_n;
  logic [CNT_W-1:0]       det_ext;
  logic                   valid_n;
  logic                   ovf_n;
  logic                   free;
  logic                   handoff;
  state_t                 state;

  assign s_last = s[SYNC_STAGES-1];

`ifdef TOG_DEC_GLITCH_FILTER_EN
  logic s_f;
  logic stable;

  // tog_prev tracks the last accepted stable level, so a one-cycle excursion never registers.
  always_comb begin
    stable     = (s_last == s_f);
    det        = stable && (s_last != tog_prev);
    tog_prev_n = stable ? s_last : tog_prev;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s_f <= 1'b0;
    else      s_f <= s_last;
  end
`else
  always_comb begin
    det        = s_last ^ tog_prev;
    tog_prev_n = s_last;
  end
`endif

  always_comb begin
    free     = !cnt_valid || cnt_ready;
    handoff  = free && ((acc != '0) || det);
    det_ext  = {{(CNT_W-1){1'b0}}, det};
    acc_n    = acc;
    data_n   = cnt_data;
    valid_n  = cnt_valid;
    ovf_n    = ovf;
    if (handoff) begin
      valid_n = 1'b1;
      acc_n   = '0;
      // A saturated accumulator cannot absorb this cycle's event; it is counted as lost.
      if (acc == ACC_MAX) begin
        data_n = ACC_MAX;
        if (det) ovf_n = 1'b1;
      end else begin
        data_n = acc + det_ext;
      end
    end else begin
      if (cnt_valid && cnt_ready) valid_n = 1'b0;
      if (det) begin
        if (acc != ACC_MAX) acc_n = acc + 1'b1;
        else                ovf_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s         <= '0;
      tog_prev  <= 1'b0;
      evt       <= 1'b0;
      acc       <= '0;
      cnt_valid <= 1'b0;
      cnt_data  <= '0;
      ovf       <= 1'b0;
    end else begin
      s         <= {s[SYNC_STAGES-2:0], tog_in};
      tog_prev  <= tog_prev_n;
      evt       <= det;
      acc       <= acc_n;
      cnt_valid <= valid_n;
      cnt_data  <= data_n;
      ovf       <= ovf_n;
    end
  end

  // Logical state is fully implied by cnt_valid and acc; decoded only for observation.
  always_comb begin
    state = ST_PEND_ACC;
    if (acc == ACC_MAX)   state = ST_SAT;
    else if (!cnt_valid)  state = ST_EMPTY;
    else if (acc == '0)   state = ST_PEND;
    dbg_state = state;
  end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed bench for toggle_event_decoder (SYNC_STAGES=2, CNT_W=4): vector table plus
// hand-written multi-cycle sequences, with a handoff scoreboard on the valid/ready port.
module tb_toggle_event_decoder;

  localparam int SYNC = 2;
  localparam int W    = 4;
`ifdef TOG_DEC_GLITCH_FILTER_EN
  localparam int FILT = 1;
`else
  localparam int FILT = 0;
`endif

  localparam int S_EMPTY    = 0;
  localparam int S_PEND     = 1;
  localparam int S_PEND_ACC = 2;
  localparam int S_SAT      = 3;

  logic         clk;
  logic         rst;
  logic         tog_in;
  logic         evt;
  logic         cnt_valid;
  logic [W-1:0] cnt_data;
  logic         cnt_ready;
  logic         ovf;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         tog;
    logic         rdy;
    logic         e_evt;
    logic         e_valid;
    logic [W-1:0] e_data;
    logic         e_ovf;
    int           e_state;
  } vec_t;

  vec_t vecs[$];

  toggle_event_decoder #(.SYNC_STAGES(SYNC), .CNT_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .tog_in    (tog_in),
    .evt       (evt),
    .cnt_valid (cnt_valid),
    .cnt_data  (cnt_data),
    .cnt_ready (cnt_ready),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every transfer at the next rising edge must match the queue head.
  always @(negedge clk) begin
    if (rst && cnt_valid && cnt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL handoff: got unexpected cnt_data=%0d, expected no transfer", cnt_data);
      end else begin
        chk("handoff", int'(cnt_data), int'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic toggle_wait(input int n);
    tog_in = ~tog_in;
    repeat (n) step();
  endtask

  function automatic vec_t mk(logic tg, logic rd, logic ev, logic vl, logic [W-1:0] dt,
                              logic ov, int st);
    vec_t v;
    v.tog = tg; v.rdy = rd; v.e_evt = ev; v.e_valid = vl;
    v.e_data = dt; v.e_ovf = ov; v.e_state = st;
    return v;
  endfunction

  task automatic chk_all(input string tag, input int e_evt, input int e_valid, input int e_data,
                         input int e_ovf);
    chk({tag, "_evt"}, int'(evt), e_evt);
    chk({tag, "_valid"}, int'(cnt_valid), e_valid);
    chk({tag, "_data"}, int'(cnt_data), e_data);
    chk({tag, "_ovf"}, int'(ovf), e_ovf);
  endtask

  initial begin
    int n_evt;
    int sum;

    rst = 1'b0;
    tog_in = 1'b0;
    cnt_ready = 1'b0;

    // Reset held with clocks running
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0);
    chk("reset_state", int'(dbg_state), S_EMPTY);
    rst = 1'b1;

    // Single toggle with ready held high
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, S_EMPTY));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, S_EMPTY));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, S_EMPTY));
    if (FILT != 0) vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, S_EMPTY));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 1'b0, S_PEND));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, S_EMPTY));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, S_EMPTY));
    exp_q.push_back(4'd1);
    for (int i = 0; i < vecs.size(); i++) begin
      tog_in = vecs[i].tog;
      cnt_ready = vecs[i].rdy;
      step();
      chk($sformatf("vec%0d_evt", i), int'(evt), int'(vecs[i].e_evt));
      chk($sformatf("vec%0d_valid", i), int'(cnt_valid), int'(vecs[i].e_valid));
      chk($sformatf("vec%0d_data", i), int'(cnt_data), int'(vecs[i].e_data));
      chk($sformatf("vec%0d_ovf", i), int'(ovf), int'(vecs[i].e_ovf));
      chk($sformatf("vec%0d_state", i), int'(dbg_state), vecs[i].e_state);
    end

    // Five toggles with consumer stalled: first count held, remaining four accumulate
    cnt_ready = 1'b0;
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd4);
    repeat (5) toggle_wait(4);
    chk_all("stall5", 0, 1, 1, 0);
    chk("stall5_state", int'(dbg_state), S_PEND_ACC);
    cnt_ready = 1'b1;
    step();
    chk_all("drain4", 0, 1, 4, 0);
    chk("drain4_state", int'(dbg_state), S_PEND);
    step();
    chk("drain4_empty_valid", int'(cnt_valid), 0);
    cnt_ready = 1'b0;

    // Twenty toggles saturate the 4-bit accumulator
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd15);
    repeat (20) toggle_wait(4);
    chk_all("sat", 0, 1, 1, 1);
    chk("sat_state", int'(dbg_state), S_SAT);
    cnt_ready = 1'b1;
    step();
    chk_all("sat_drain", 0, 1, 15, 1);
    chk("sat_drain_state", int'(dbg_state), S_PEND);
    step();
    chk("sat_after_valid", int'(cnt_valid), 0);
    chk("sat_after_ovf", int'(ovf), 1);
    chk("sat_after_state", int'(dbg_state), S_EMPTY);
    cnt_ready = 1'b0;

    // Event coinciding with the edge that consumes a pending count (acc=3)
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd4);
    repeat (4) toggle_wait(4);
    chk("coin_pre_data", int'(cnt_data), 1);
    chk("coin_pre_state", int'(dbg_state), S_PEND_ACC);
    tog_in = ~tog_in;
    step();
    step();
    if (FILT != 0) step();
    chk("coin_pre_valid", int'(cnt_valid), 1);
    cnt_ready = 1'b1;
    step();
    chk_all("coin", 1, 1, 4, 1);
    step();
    chk("coin_after_valid", int'(cnt_valid), 0);

    // One-sampled-cycle pulse on tog_in
    if (FILT == 0) begin
      exp_q.push_back(4'd1);
      exp_q.push_back(4'd1);
    end
    n_evt = 0;
    sum = 0;
    tog_in = ~tog_in;
    step();
    n_evt += int'(evt);
    if (cnt_valid) sum += int'(cnt_data);
    tog_in = ~tog_in;
    repeat (8) begin
      step();
      n_evt += int'(evt);
      if (cnt_valid) sum += int'(cnt_data);
    end
    chk("glitch_evts", n_evt, (FILT != 0) ? 0 : 2);
    chk("glitch_sum", sum, (FILT != 0) ? 0 : 2);
    chk("glitch_ovf", int'(ovf), 1);
    cnt_ready = 1'b0;

    // Asynchronous reset with a count pending and ovf set
    repeat (3) toggle_wait(4);
    chk("prerst_valid", int'(cnt_valid), 1);
    chk("prerst_state", int'(dbg_state), S_PEND_ACC);
    #2;
    tog_in = 1'b1;
    rst = 1'b0;
    #1;
    chk_all("midrst", 0, 0, 0, 0);
    chk("midrst_state", int'(dbg_state), S_EMPTY);
    repeat (3) @(posedge clk);
    #1;
    chk_all("midrst_hold", 0, 0, 0, 0);
    rst = 1'b1;

    // tog_in already high at release counts as one event
    repeat (SYNC + 1 + FILT) step();
    chk_all("release_evt", 1, 1, 1, 0);
    step();
    chk("release_after_evt", int'(evt), 0);
    chk("release_hold_data", int'(cnt_data), 1);

    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
